// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: shadows a packed hex value
// and scans one digit per refresh slot, each slot opening with a dark guard interval.
//
// state | meaning
// GUARD | cnt < GUARD, all anodes off to suppress ghosting
// SHOW  | cnt >= GUARD, current digit driven unless leading-zero blanked
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
  localparam logic [DW-1:0] D_LAST   = DW'(DIGITS - 1);

  typedef enum logic {ST_GUARD, ST_SHOW} state_t;

  logic [CW-1:0]         cnt, cnt_next;
  logic [DW-1:0]         d, d_next;
  logic                  cnt_wrap, d_last;
  state_t                state_next;
  logic [4*DIGITS-1:0]   shadow_val;
  logic [DIGITS-1:0]     shadow_dp;
  logic [3:0]            nib;
  logic                  dp_sel, blanked, zero_run;
  logic [DIGITS-1:0]     an_sel, an_next;
  logic [6:0]            seg_next;
  logic                  dp_n_next;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    cnt_wrap = (cnt == CNT_LAST);
    d_last   = (d == D_LAST);
    cnt_next = cnt_wrap ? '0 : cnt + 1'b1;
    d_next   = d;
    if (cnt_wrap) d_next = d_last ? '0 : d + 1'b1;
    state_next = (cnt_next < GUARD_C) ? ST_GUARD : ST_SHOW;
  end

  // Outputs look ahead to the digit/phase the counter moves into on this edge.
  always_comb begin
    nib      = 4'h0;
    dp_sel   = 1'b0;
    blanked  = 1'b0;
    zero_run = 1'b1;
    an_sel   = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (shadow_val[4*i +: 4] == 4'h0);
      if (d_next == DW'(i)) begin
        nib       = shadow_val[4*i +: 4];
        dp_sel    = shadow_dp[i];
        blanked   = blank_lz && (i != 0) && zero_run;
        an_sel[i] = 1'b0;
      end
    end
    an_next   = '1;
    seg_next  = 7'b1111111;
    dp_n_next = 1'b1;
    if (state_next == ST_SHOW && !blanked) begin
      an_next   = an_sel;
      seg_next  = decode(nib);
      dp_n_next = ~dp_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      d          <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      an         <= '1;
      seg        <= 7'b1111111;
      dp_n       <= 1'b1;
      frame      <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      d     <= d_next;
      an    <= an_next;
      seg   <= seg_next;
      dp_n  <= dp_n_next;
      frame <= cnt_wrap && d_last;
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, REFRESH_DIV=8, GUARD=2:
// a vector table of display snapshots plus hand-written reset/load sequences.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame;

  int n_checks = 0;
  int n_fail = 0;
  int ek = 0;
  bit mon_en = 1'b0;

  seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(8), .GUARD(2)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .seg(seg), .dp_n(dp_n), .an(an), .frame(frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        bl;
    int          k;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [15:0] v, input logic [3:0] dp, input logic bl, input int k,
                     input logic [3:0] a, input logic [6:0] s, input logic dn, input logic fr);
    vec_t t;
    t = '{value: v, dp: dp, bl: bl, k: k, an: a, seg: s, dp_n: dn, frame: fr};
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] a, input logic [6:0] s,
                         input logic dn, input logic fr);
    chk({name, " an"}, {4'h0, an}, {4'h0, a});
    chk({name, " seg"}, {1'b0, seg}, {1'b0, s});
    chk({name, " dp_n"}, {7'h0, dp_n}, {7'h0, dn});
    chk({name, " frame"}, {7'h0, frame}, {7'h0, fr});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ek++;
  endtask

  // Reset at E0 with load held, capture the shadow at E1, then release load.
  task automatic reset_seq(input logic [15:0] v, input logic [3:0] dp, input logic bl);
    rst = 1'b1; load = 1'b1; value = v; dp_in = dp; blank_lz = bl;
    step();
    ek = 0;
    rst = 1'b0;
    step();
    load = 1'b0;
  endtask

  task automatic run_to(input int k);
    for (int n = 0; n < 200 && ek < k; n++) step();
  endtask

  // At most one anode low on every cycle once reset has been seen.
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if ($countones(~an) > 1) begin
        n_fail++;
        $display("FAIL onehot an: got %b expected at most one low bit", an);
      end
    end
  end

  initial begin
    add(16'h1234, 4'b0100, 1'b0,  2, 4'b1110, 7'b0011001, 1'b1, 1'b0);
    add(16'h1234, 4'b0100, 1'b0,  7, 4'b1110, 7'b0011001, 1'b1, 1'b0);
    add(16'h1234, 4'b0100, 1'b0,  8, 4'b1111, 7'b1111111, 1'b1, 1'b0);
    add(16'h1234, 4'b0100, 1'b0,  9, 4'b1111, 7'b1111111, 1'b1, 1'b0);
    add(16'h1234, 4'b0100, 1'b0, 10, 4'b1101, 7'b0110000, 1'b1, 1'b0);
    add(16'h1234, 4'b0100, 1'b0, 15, 4'b1101, 7'b0110000, 1'b1, 1'b0);
    add(16'h1234, 4'b0100, 1'b0, 18, 4'b1011, 7'b0100100, 1'b0, 1'b0);
    add(16'h1234, 4'b0100, 1'b0, 23, 4'b1011, 7'b0100100, 1'b0, 1'b0);
    add(16'h1234, 4'b0100, 1'b0, 26, 4'b0111, 7'b1111001, 1'b1, 1'b0);
    add(16'h1234, 4'b0100, 1'b0, 31, 4'b0111, 7'b1111001, 1'b1, 1'b0);
    add(16'h1234, 4'b0100, 1'b0, 32, 4'b1111, 7'b1111111, 1'b1, 1'b1);
    add(16'h1234, 4'b0100, 1'b0, 33, 4'b1111, 7'b1111111, 1'b1, 1'b0);
    add(16'h1234, 4'b0100, 1'b0, 34, 4'b1110, 7'b0011001, 1'b1, 1'b0);
    add(16'h0045, 4'b0000, 1'b1,  2, 4'b1110, 7'b0010010, 1'b1, 1'b0);
    add(16'h0045, 4'b0000, 1'b1, 10, 4'b1101, 7'b0011001, 1'b1, 1'b0);
    add(16'h0045, 4'b0000, 1'b1, 18, 4'b1111, 7'b1111111, 1'b1, 1'b0);
    add(16'h0045, 4'b0000, 1'b1, 26, 4'b1111, 7'b1111111, 1'b1, 1'b0);
    add(16'h0045, 4'b0000, 1'b0, 18, 4'b1011, 7'b1000000, 1'b1, 1'b0);
    add(16'h0045, 4'b0000, 1'b0, 26, 4'b0111, 7'b1000000, 1'b1, 1'b0);
    add(16'h0000, 4'b1000, 1'b1,  2, 4'b1110, 7'b1000000, 1'b1, 1'b0);
    add(16'h0000, 4'b1000, 1'b1, 10, 4'b1111, 7'b1111111, 1'b1, 1'b0);
    add(16'h0000, 4'b1000, 1'b1, 26, 4'b1111, 7'b1111111, 1'b1, 1'b0);
    add(16'h0000, 4'b0001, 1'b1,  4, 4'b1110, 7'b1000000, 1'b0, 1'b0);
    add(16'h0405, 4'b0000, 1'b1, 10, 4'b1101, 7'b1000000, 1'b1, 1'b0);
    add(16'h0405, 4'b0000, 1'b1, 18, 4'b1011, 7'b0011001, 1'b1, 1'b0);
    add(16'h0405, 4'b0000, 1'b1, 26, 4'b1111, 7'b1111111, 1'b1, 1'b0);
    add(16'h9876, 4'b0000, 1'b0,  2, 4'b1110, 7'b0000010, 1'b1, 1'b0);
    add(16'h9876, 4'b0000, 1'b0, 10, 4'b1101, 7'b1111000, 1'b1, 1'b0);
    add(16'h9876, 4'b0000, 1'b0, 18, 4'b1011, 7'b0000000, 1'b1, 1'b0);
    add(16'h9876, 4'b0000, 1'b0, 26, 4'b0111, 7'b0010000, 1'b1, 1'b0);
    add(16'hFEDC, 4'b1010, 1'b0,  2, 4'b1110, 7'b1000110, 1'b1, 1'b0);
    add(16'hFEDC, 4'b1010, 1'b0, 10, 4'b1101, 7'b0100001, 1'b0, 1'b0);
    add(16'hFEDC, 4'b1010, 1'b0, 18, 4'b1011, 7'b0000110, 1'b1, 1'b0);
    add(16'hFEDC, 4'b1010, 1'b0, 26, 4'b0111, 7'b0001110, 1'b0, 1'b0);
    add(16'h05AB, 4'b0000, 1'b1,  2, 4'b1110, 7'b0000011, 1'b1, 1'b0);
    add(16'h05AB, 4'b0000, 1'b1, 10, 4'b1101, 7'b0001000, 1'b1, 1'b0);
    add(16'h05AB, 4'b0000, 1'b1, 18, 4'b1011, 7'b0010010, 1'b1, 1'b0);
    add(16'h05AB, 4'b0000, 1'b1, 26, 4'b1111, 7'b1111111, 1'b1, 1'b0);

    // Reset held 3 cycles with load=1 must keep outputs dark and shadow at 0.
    rst = 1'b1; load = 1'b1; value = 16'hFFFF; dp_in = 4'b1111; blank_lz = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      mon_en = 1'b1;
      chk_out($sformatf("reset c%0d", c), 4'b1111, 7'b1111111, 1'b1, 1'b0);
    end
    ek = 0;
    rst = 1'b0; load = 1'b0; blank_lz = 1'b1;
    step();
    chk_out("post-reset E1", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    run_to(2);
    chk_out("post-reset E2 shadow0", 4'b1110, 7'b1000000, 1'b1, 1'b0);
    run_to(10);
    chk_out("post-reset E10 blanked", 4'b1111, 7'b1111111, 1'b1, 1'b0);

    foreach (vecs[i]) begin
      reset_seq(vecs[i].value, vecs[i].dp, vecs[i].bl);
      run_to(vecs[i].k);
      chk_out($sformatf("vec%0d %h E%0d", i, vecs[i].value, vecs[i].k),
              vecs[i].an, vecs[i].seg, vecs[i].dp_n, vecs[i].frame);
    end

    // Mid-slot load: new digit appears one edge after the load edge; slot timing unchanged.
    reset_seq(16'h1234, 4'b0000, 1'b0);
    run_to(4);
    value = 16'hABCD; load = 1'b1;
    step();
    load = 1'b0;
    chk_out("midload E5 old", 4'b1110, 7'b0011001, 1'b1, 1'b0);
    step();
    chk_out("midload E6 new", 4'b1110, 7'b0100001, 1'b1, 1'b0);
    run_to(7);
    chk_out("midload E7", 4'b1110, 7'b0100001, 1'b1, 1'b0);
    run_to(8);
    chk_out("midload E8 end", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    run_to(10);
    chk_out("midload E10 C", 4'b1101, 7'b1000110, 1'b1, 1'b0);

    // load held high tracks value every cycle.
    reset_seq(16'h0000, 4'b0000, 1'b0);
    run_to(2);
    value = 16'h0001; load = 1'b1;
    step();
    value = 16'h0002;
    step();
    chk_out("track E4", 4'b1110, 7'b1111001, 1'b1, 1'b0);
    step();
    load = 1'b0;
    chk_out("track E5", 4'b1110, 7'b0100100, 1'b1, 1'b0);

    // Reset during digit 2 SHOW aborts the slot and clears the shadow.
    reset_seq(16'h1234, 4'b0100, 1'b0);
    run_to(19);
    chk_out("midrst E19", 4'b1011, 7'b0100100, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk_out("midrst E20", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    rst = 1'b0;
    ek = 0;
    step();
    chk_out("midrst +1", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    step();
    chk_out("midrst +2", 4'b1110, 7'b1000000, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed 7-segment display driver. It sits downstream of the button-driven counter and shows its count values as hex digits on a common-anode multi-digit display.
It latches a packed hex value on a load strobe and scans one digit per refresh slot. Each slot opens with a guard interval, with all anodes off, to suppress ghosting.
Optional leading-zero blanking and per-digit decimal points are supported.

Parameters:
DIGITS, 4, number of digits scanned; legal range 1..8.
REFRESH_DIV, 100000, clock cycles per digit slot, guard included; must be > GUARD.
GUARD, 1000, cycles at the start of each slot with all anodes inactive; must be >= 1.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous reset, active-high.
value  input  4*DIGITS  packed hex nibbles; nibble i = value[4i+3:4i]; digit 0 is least significant (rightmost).
dp_in  input  DIGITS  decimal point request per digit, 1 = lit.
load  input  1  when high at a clock edge, value/dp_in are captured into shadow registers.
blank_lz  input  1  1 = blank leading zero digits.
seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
dp_n  output  1  decimal point, active-low, registered.
an  output  DIGITS  digit anodes, active-low, one-hot-low or all high, registered.
frame  output  1  one-cycle pulse when scan wraps from digit DIGITS-1 to digit 0.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst sampled high at an edge):
  - Next outputs: an = all 1, seg = 7'b1111111, dp_n = 1, frame = 0.
  - Internal: slot counter cnt = 0, digit index d = 0, shadow value = 0, shadow dp = 0.
  - Reset mid-scan aborts the slot immediately; there is no partial-slot completion.
- Slot counter: cnt runs 0..REFRESH_DIV-1 and increments every cycle. On wrap to 0, d <= (d == DIGITS-1) ? 0 : d+1.
- Edge numbering: E0 is the edge where rst is sampled high; Ek is the k-th edge after rst falls.
- States:
  - GUARD while cnt < GUARD.
  - SHOW while cnt >= GUARD.
- Outputs are registered and updated on the same edge as cnt. After the edge that sets cnt:
  - GUARD: an = all 1, seg = all 1, dp_n = 1.
  - SHOW, digit d not blanked: an[d] = 0 (others 1), seg = decode(shadow nibble d), dp_n = ~shadow_dp[d].
  - SHOW, digit d blanked: an = all 1, seg = all 1, dp_n = 1.
- Slot timing:
  - After reset, digit 0 goes active at edge E_GUARD and stays active through E_(REFRESH_DIV-1).
  - Digit 0 goes inactive at E_REFRESH_DIV.
- Blanking:
  - Applies only when blank_lz = 1.
  - Digit i > 0 is blanked iff shadow nibbles i..DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - dp requests on blanked digits are suppressed.
  - blank_lz is evaluated live each cycle (not shadowed).
- Load:
  - Shadow registers update on the edge where load = 1.
  - A displayed change appears on seg/dp_n at the following edge (1-cycle latency), even mid-SHOW; an is unaffected.
  - load held high continuously tracks value every cycle.
  - load and rst in the same cycle: rst wins and shadow becomes 0.
- frame:
  - High for exactly the cycle following the edge where cnt wraps to 0 and d wraps DIGITS-1 -> 0.
  - With DIGITS = 1, frame pulses every slot.
- Decode (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Invariant: an never has more than one bit low. an is all 1 during every GUARD cycle.

Test Plan:
All scenarios use DIGITS=4, REFRESH_DIV=8, GUARD=2.
1. Reset: rst high 3 cycles with load=1, value=16'hFFFF -> an=4'b1111, seg=7'b1111111, dp_n=1, frame=0 throughout, and shadow remains 0.
2. Scan order:
   - Stimulus: load 16'h1234, dp_in=4'b0100, blank_lz=0, then rst low.
   - E2..E7: an=1110, seg=0011001 ("4"), dp_n=1.
   - E8, E9: an=1111.
   - E10..E15: an=1101, seg=0110000 ("3").
   - E18..E23: an=1011, seg=0100100, dp_n=0.
   - E26..E31: an=0111, seg=1111001.
   - frame=1 only after E32.
3. Leading-zero blanking:
   - value 16'h0045, blank_lz=1 -> digits 3 and 2 never drive an low across a full frame; digits 1 and 0 show "4" and "5".
   - Same value with blank_lz=0 -> digits 3 and 2 show 1000000.
4. All zero: value 16'h0000, blank_lz=1, dp_in=4'b1000 -> only digit 0 shows 1000000; digit 3 stays dark with dp_n=1.
5. Mid-slot load: digit 0 showing value 16'h1234 at cnt=4, pulse load with 16'hABCD -> seg becomes 0100001 ("d") one edge later, an stays 1110, and the slot end is unchanged at E8.
6. Reset mid-op: assert rst at E20 (digit 2 SHOW) for one cycle -> next edge gives an=1111 and shadow=0; digit 0 is active again 2 edges after rst falls.
